// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port frame-buffer RAM between the display pixel fetch and
// a buffered writer. Display reads always win; writes are parked in a small
// FIFO and trickle into the RAM on cycles the display does not need the port.
//
// Parameters
//   AW     frame-buffer address width (640x480 words -> 19 bits)
//   DW     pixel / data width (RGB444 -> 12 bits)
//   DEPTH  write-buffer entries, power of two, at least 2
//
// Ports
//   clk_vga     pixel clock, the only clock of the block
//   rst_n       asynchronous active-low reset; release is re-timed inside
//   pix_req     display wants a pixel this cycle
//   pix_addr    address of that pixel
//   pix_data    fetched pixel, registered, holds when pix_valid=0
//   pix_valid   pix_data carries a new pixel this cycle (3 cycles after req)
//   wr_valid    writer offers a word
//   wr_addr     write address
//   wr_data     write data
//   wr_ready    buffer has room; transfer when wr_valid && wr_ready
//   mem_en      RAM enable (registered)
//   mem_we      RAM write enable (registered)
//   mem_addr    RAM address (registered, holds while idle)
//   mem_wdata   RAM write data (registered, holds while idle)
//   mem_rdata   RAM read data, valid the cycle after a read cycle
//   fifo_count  write-buffer occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int AW    = 19,
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk_vga,
  input  logic                       rst_n,
  input  logic                       pix_req,
  input  logic [AW-1:0]              pix_addr,
  output logic [DW-1:0]              pix_data,
  output logic                       pix_valid,
  input  logic                       wr_valid,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_ready,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Port FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          arb_en;
  logic          rd_pend;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];

  // ---------------------------------------------------------------------------
  // Reset release re-timing. Assertion clears everything at once; on release
  // this flag rises on the first edge, so the first arbitration happens on the
  // second edge after rst_n goes high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      arb_en <= 1'b0;
    end else begin
      arb_en <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration: display first, then a buffered write, else idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = ST_IDLE;
    if (arb_en) begin
      if (pix_req) begin
        state_d = ST_READ;
      end else if (count_q != '0) begin
        state_d = ST_WRITE;
      end
    end
  end

  // Room is judged from the registered count only, so a pop on this edge
  // frees a slot that becomes visible on the next cycle.
  assign wr_ready   = (count_q < CW'(DEPTH));
  assign push       = wr_valid && wr_ready;
  assign pop        = (state_d == ST_WRITE);
  assign fifo_count = count_q;

  // ---------------------------------------------------------------------------
  // Write buffer storage.
  // ---------------------------------------------------------------------------
  // NOTE: the entry array is deliberately left out of reset; entries are only
  // ever read below the occupancy count, which is reset, so stale contents
  // are harmless and the array can map onto plain registers or LUT RAM.
  always_ff @(posedge clk_vga) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Push and pop together leave the occupancy where it is.
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port drive. All RAM controls are registered; address and write data
  // hold through idle cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_vga or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop in
    // this block samples pre-edge values, matching the hardware it models.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      case (state_d)
        ST_READ: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pix_addr;
        end
        ST_WRITE: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= fifo_addr[rd_ptr];
          mem_wdata <= fifo_data[rd_ptr];
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path. The read cycle is the cycle after the request edge; the
  // RAM answers one cycle later, and the pixel is captured on the edge after
  // that. Each stage is a single flop, so back-to-back requests stream out
  // back-to-back in request order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend   <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      rd_pend   <= (state_q == ST_READ);
      pix_valid <= rd_pend;
      if (rd_pend) begin
        pix_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Directed and random stimulus for vga_fb_arbiter. A behavioural RAM sits on
// the memory port. The expected behaviour comes from a cycle-level model of
// the arbitration rules: display requests win, a queued write goes out when
// the display is quiet, the buffer holds up to DEPTH words, pixels return
// three cycles after the request. Reads use the upper half of the address
// space and writes the lower half, so read data never depends on the
// unordered read-after-write behaviour.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk_vga;
  logic          rst_n;
  logic          pix_req;
  logic [AW-1:0] pix_addr;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] fifo_count;

  vga_fb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_vga    (clk_vga),
    .rst_n      (rst_n),
    .pix_req    (pix_req),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_count (fifo_count)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  // ---------------------------------------------------------------------------
  // Behavioural single-port RAM: write on a write cycle, read data one cycle
  // after a read cycle. Unwritten words hold a fixed address-derived pattern.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram  [logic [AW-1:0]];
  logic [DW-1:0] gold [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 12'h5A5;
  endfunction

  always @(posedge clk_vga) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) begin
        ram[mem_addr] = mem_wdata;
      end else begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state.
  // ---------------------------------------------------------------------------
  int            n_cmp;
  int            n_err;
  wr_t           offer_q [$];   // words the writer still has to hand over
  wr_t           mdl_q   [$];   // words accepted but not yet in RAM
  int            mcnt;          // expected occupancy
  int            rel_edges;     // clock edges since reset release
  bit            v1, v2;        // reads issued one and two edges ago
  logic [DW-1:0] d1, d2;        // their expected pixel values
  logic [DW-1:0] last_pd;       // pixel value the output should be holding
  logic [AW-1:0] last_ma;       // RAM address the port should be holding

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] gold_rd(input logic [AW-1:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  function automatic logic [AW-1:0] rd_addr_rand();
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[AW-1] = 1'b1;
    return a;
  endfunction

  function automatic logic [AW-1:0] wr_addr_rand();
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[AW-1] = 1'b0;
    return a;
  endfunction

  task automatic model_reset();
    mdl_q.delete();
    offer_q.delete();
    mcnt      = 0;
    rel_edges = 0;
    v1 = 1'b0; v2 = 1'b0;
    d1 = '0;   d2 = '0;
    last_pd = '0;
    last_ma = '0;
  endtask

  // One clock cycle: drive at the current point (before the rising edge),
  // advance the model across the edge, compare on the falling edge.
  task automatic step(input bit req, input logic [AW-1:0] raddr);
    bit            exp_ready;
    bit            push;
    bit            pop;
    bit            rd;
    bit            ev;
    logic [DW-1:0] ed;
    wr_t           w;
    wr_t           ew;

    exp_ready = (mcnt < DEPTH);
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));

    pix_req  = req;
    pix_addr = raddr;
    w        = '0;
    if (offer_q.size() > 0) begin
      w        = offer_q[0];
      wr_valid = 1'b1;
      wr_addr  = w.a;
      wr_data  = w.d;
    end else begin
      wr_valid = 1'b0;
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
    end
    push = wr_valid && exp_ready;

    @(posedge clk_vga);
    rel_edges++;
    rd  = (rel_edges >= 2) && req;
    pop = (rel_edges >= 2) && !req && (mcnt > 0);
    ew  = '0;
    if (pop) begin
      ew = mdl_q.pop_front();
      gold[ew.a] = ew.d;
    end
    if (push) begin
      mdl_q.push_back(w);
      void'(offer_q.pop_front());
    end
    mcnt = mcnt + int'(push) - int'(pop);
    ev = v2; ed = d2;
    v2 = v1; d2 = d1;
    v1 = rd; d1 = gold_rd(raddr);

    @(negedge clk_vga);
    check("mem_en", 32'(mem_en), 32'(rd || pop));
    check("mem_we", 32'(mem_we), 32'(pop));
    if (rd) begin
      check("rd_addr", 32'(mem_addr), 32'(raddr));
      last_ma = raddr;
    end else if (pop) begin
      check("wr_addr_order", 32'(mem_addr), 32'(ew.a));
      check("wr_data_order", 32'(mem_wdata), 32'(ew.d));
      last_ma = ew.a;
    end else begin
      check("idle_addr_hold", 32'(mem_addr), 32'(last_ma));
    end
    check("fifo_count", 32'(fifo_count), 32'(mcnt));
    check("fifo_le_depth", 32'(fifo_count <= CW'(DEPTH)), 32'd1);
    check("pix_valid", 32'(pix_valid), 32'(ev));
    if (ev) last_pd = ed;
    check("pix_data", 32'(pix_data), 32'(last_pd));
  endtask

  // Run idle display cycles until every buffered word and pixel is out.
  task automatic drain();
    while (mcnt > 0 || offer_q.size() > 0 || v1 || v2) begin
      step(1'b0, rd_addr_rand());
    end
    step(1'b0, rd_addr_rand());
  endtask

  task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    offer_q.push_back(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n    = 1'b0;
    pix_req  = 1'b0;
    pix_addr = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    model_reset();

    // Reset values with the clock running.
    @(negedge clk_vga);
    @(negedge clk_vga);
    check("rst_mem_en",    32'(mem_en),     32'd0);
    check("rst_mem_we",    32'(mem_we),     32'd0);
    check("rst_mem_addr",  32'(mem_addr),   32'd0);
    check("rst_mem_wdata", 32'(mem_wdata),  32'd0);
    check("rst_pix_valid", 32'(pix_valid),  32'd0);
    check("rst_pix_data",  32'(pix_data),   32'd0);
    check("rst_fifo_cnt",  32'(fifo_count), 32'd0);
    check("rst_wr_ready",  32'(wr_ready),   32'd1);
    rst_n = 1'b1;
    model_reset();

    // Release timing: a request on the first edge is ignored, the second is
    // served.
    step(1'b1, 19'h40123);
    step(1'b1, 19'h40124);
    drain();

    // Single read of a preloaded word: pixel three cycles later.
    ram[19'h00010]  = 12'hABC;
    gold[19'h00010] = 12'hABC;
    step(1'b1, 19'h00010);
    step(1'b0, rd_addr_rand());
    step(1'b0, rd_addr_rand());
    step(1'b0, rd_addr_rand());
    check("single_read_pix", 32'(pix_data), 32'h0ABC);
    step(1'b0, rd_addr_rand());

    // Idle drain of four writes.
    for (int i = 1; i <= 4; i++) offer(AW'(i), DW'(12'h111 * i));
    drain();
    for (int i = 1; i <= 4; i++) begin
      check("idle_drain_ram", 32'(ram[AW'(i)]), 32'(12'h111 * i));
    end

    // Full buffer under a continuous display burst, then release.
    for (int i = 0; i < 6; i++) offer(AW'(19'h00200 + i), DW'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, rd_addr_rand());
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    check("full_ready", 32'(wr_ready), 32'd0);
    drain();

    // Simultaneous push and pop at occupancy 2.
    offer(19'h00300, 12'h301);
    offer(19'h00301, 12'h302);
    step(1'b1, rd_addr_rand());
    step(1'b1, rd_addr_rand());
    offer(19'h00302, 12'h303);
    step(1'b0, rd_addr_rand());
    check("push_pop_count", 32'(fifo_count), 32'd2);
    drain();

    // Ten writes streamed back-to-back wrap the pointers.
    for (int i = 0; i < 10; i++) offer(AW'(19'h00400 + i), DW'($urandom));
    drain();
    for (int i = 0; i < 10; i++) begin
      check("wrap_ram", 32'(ram[AW'(19'h00400 + i)]),
            32'(gold[AW'(19'h00400 + i)]));
    end

    // Reset mid-operation: three buffered words, two reads in flight.
    for (int i = 0; i < 3; i++) offer(AW'(19'h00500 + i), DW'($urandom));
    for (int i = 0; i < 4; i++) step(1'b1, rd_addr_rand());
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    wr_valid = 1'b0;
    pix_req  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_mem_en",    32'(mem_en),     32'd0);
    check("async_mem_we",    32'(mem_we),     32'd0);
    check("async_mem_addr",  32'(mem_addr),   32'd0);
    check("async_mem_wdata", 32'(mem_wdata),  32'd0);
    check("async_pix_valid", 32'(pix_valid),  32'd0);
    check("async_pix_data",  32'(pix_data),   32'd0);
    check("async_fifo_cnt",  32'(fifo_count), 32'd0);
    check("async_wr_ready",  32'(wr_ready),   32'd1);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) step(1'b0, rd_addr_rand());

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if (offer_q.size() < 3 && $urandom_range(0, 2) == 0) begin
        offer(wr_addr_rand(), DW'($urandom));
      end
      step($urandom_range(0, 99) < 60, rd_addr_rand());
    end
    drain();

    // Every word the model retired must be in the RAM.
    foreach (gold[a]) begin
      check("ram_final", ram.exists(a) ? 32'(ram[a]) : 32'hFFFF_FFFF,
            32'(gold[a]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter AW, default 19: frame-buffer address width (640x480 words).
REQ-002 Parameter DW, default 12: pixel/data width (RGB444).
REQ-003 Parameter DEPTH, default 4: write-buffer entries, power of two, at least 2.
REQ-004 clk_vga  input  1  single clock for the whole block (25 MHz pixel clock).
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pix_req  input  1  pixel-fetch request for this cycle, from the display side.
REQ-007 pix_addr  input  AW  pixel-fetch address, valid when pix_req=1.
REQ-008 pix_data  output  DW  fetched pixel.
REQ-009 pix_valid  output  1  pix_data valid this cycle.
REQ-010 wr_valid  input  1  writer offers a word.
REQ-011 wr_addr  input  AW  write address.
REQ-012 wr_data  input  DW  write data.
REQ-013 wr_ready  output  1  block accepts the word; a transfer occurs when wr_valid=1 and wr_ready=1.
REQ-014 mem_en  output  1  single-port RAM enable, registered.
REQ-015 mem_we  output  1  RAM write enable, registered.
REQ-016 mem_addr  output  AW  RAM address, registered.
REQ-017 mem_wdata  output  DW  RAM write data, registered.
REQ-018 mem_rdata  input  DW  RAM read data, valid the cycle after a read cycle (mem_en=1, mem_we=0).
REQ-019 fifo_count  output  clog2(DEPTH)+1  current write-buffer occupancy.

Function
REQ-020 The block shall arbitrate one single-port RAM between display reads and buffered writes.
- Display reads have absolute priority.
REQ-021 Port FSM states: IDLE, READ, WRITE. State is evaluated at each clk_vga edge:
- pix_req=1 -> READ.
- else fifo_count>0 -> WRITE.
- else -> IDLE.
REQ-022 In READ the block shall drive mem_en=1, mem_we=0, mem_addr = pix_addr sampled at that edge.
REQ-023 In WRITE the block shall drive mem_en=1, mem_we=1, with mem_addr/mem_wdata taken from the FIFO head, and shall pop the head in the same edge.
REQ-024 In IDLE the block shall drive mem_en=0 and mem_we=0; mem_addr and mem_wdata shall hold their previous values.
REQ-025 Read latency: pix_req sampled at edge N gives mem_en at N..N+1 and mem_rdata in cycle N+1..N+2. pix_data shall register mem_rdata at edge N+2, with pix_valid=1 for exactly that one cycle (3-cycle latency).
REQ-026 Back-to-back pix_req shall produce back-to-back pix_valid, in request order, with no bubbles.
REQ-027 When pix_valid=0, pix_data shall hold its last value.
REQ-028 Write buffer: a DEPTH-entry FIFO with circular read/write pointers that wrap modulo DEPTH.
REQ-029 wr_ready = (fifo_count < DEPTH), decoded from the registered count. A pop in the same cycle shall not raise wr_ready until the next cycle.
REQ-030 Simultaneous push and pop shall leave fifo_count unchanged and preserve FIFO order.
REQ-031 Writes shall reach RAM in acceptance order. Read-after-write ordering across the two ports is not guaranteed.
REQ-032 fifo_count shall never exceed DEPTH and shall never underflow; the FSM shall not enter WRITE when fifo_count=0.
REQ-033 With pix_req held high continuously, buffered writes shall stall indefinitely with no loss. Draining resumes on the first cycle with pix_req=0.

Reset
REQ-034 While rst_n=0, all of the following shall be 0:
- state (IDLE), FIFO pointers, fifo_count
- mem_en, mem_we, mem_addr, mem_wdata
- pix_valid, pix_data
REQ-035 Reset is asynchronous on assertion; outputs shall clear without waiting for a clock edge.
REQ-036 wr_ready shall be 1 while rst_n=0 and after release.
REQ-037 Reset mid-operation shall discard FIFO contents and all in-flight reads; no pix_valid shall appear for requests issued before reset.
REQ-038 Release shall be synchronized internally; the first arbitration shall occur on the second edge after rst_n rises.

Verification
REQ-039 Single read: pix_req=1, pix_addr=0x00010 for one cycle, RAM model holding 0xABC there -> one mem read of 0x00010, then pix_valid=1 with pix_data=0xABC exactly 3 cycles later.
REQ-040 Idle drain: pix_req=0; push 4 writes (addr 1..4, data 0x111..0x444) -> four consecutive mem_we=1 cycles in order; fifo_count returns to 0; wr_ready stays 1.
REQ-041 Full/stall: pix_req=1 for 20 cycles; offer 6 writes -> 4 accepted, wr_ready=0 with fifo_count=4, no mem_we. After pix_req falls, 4 writes drain, then the remaining 2 are accepted and written.
REQ-042 Simultaneous push/pop: fifo_count=2, pix_req=0, a push the same cycle -> fifo_count stays 2; RAM receives writes in acceptance order.
REQ-043 Pointer wrap: 10 writes streamed at 1/cycle with pix_req=0 -> all 10 land at the correct addresses; fifo_count never exceeds DEPTH.
REQ-044 Reset mid-op: fifo_count=3 and 2 reads in flight, pulse rst_n low for 1 ns between edges -> outputs clear immediately; no subsequent pix_valid or mem_we until new requests arrive.
